// File: rtl/vdp_reg_arb_pkg.sv
// Shared types and helpers for the VDP register-write arbiter.
// Default address/data widths, the {addr, data} entry layout used by the
// register decode, and the fixed-priority winner selection.
package vdp_reg_arb_pkg;

  localparam int VDP_ADDR_W = 5;
  localparam int VDP_DATA_W = 16;

  // One register write at the default widths, as seen by the register decode.
  typedef struct packed {
    logic [VDP_ADDR_W-1:0] addr;
    logic [VDP_DATA_W-1:0] data;
  } vdp_reg_entry_t;

  // Index of the lowest set bit; 0 when no bit is set. Callers zero-extend
  // their strobe vectors, so at most 32 channels are supported.
  function automatic int lowest_set(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vdp_reg_fifo.sv
// Purpose: synchronous FIFO holding buffered host register writes.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: push is ignored when full and pop when empty; callers gate on full/empty.
module vdp_reg_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign full     = (level == (PTR_W+1)'(DEPTH));
  assign empty    = (level == '0);

  // Pointers wrap naturally because DEPTH is a power of two; level is explicit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vdp_reg_arbiter.sv
// Purpose: merges a FIFO-buffered host write port and NUM_CH strobed channels into one register-write port; ordered host reads.
// Latency: channel strobe -> write next cycle; host accept -> ready next cycle, earliest write next cycle; read ready after READ_LATENCY.
// Backpressure: host stalls (ready low) only on a full FIFO or a pending ack/drain; channels have none and losers are dropped.
// Option: define VDP_REG_ARB_CONFLICT_COUNT_EN to count dropped channel strobes in conflict_count.
module vdp_reg_arbiter
  import vdp_reg_arb_pkg::*;
#(
  parameter int ADDR_W       = VDP_ADDR_W,
  parameter int DATA_W       = VDP_DATA_W,
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          host_address,
  input  logic                       host_write_en,
  input  logic [DATA_W-1:0]          host_write_data,
  input  logic                       host_read_en,
  output logic                       ready,
  output logic [ADDR_W-1:0]          read_address,
  input  logic [NUM_CH-1:0]          ch_write_en,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_write_address,
  input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
  input  logic                       vram_write_pending,
  output logic                       register_write_en,
  output logic [ADDR_W-1:0]          register_write_address,
  output logic [DATA_W-1:0]          register_write_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                 conflict_count
);

  localparam int RC_W = $clog2(READ_LATENCY + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          host_entry;
  entry_t          head_entry;
  entry_t          ch_entry;
  int              win_idx;
  logic            any_ch;
  logic            wr_acc;
  logic            rd_acc;
  logic            drain;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ack_pending;
  logic            fifo_issue;
  logic [RC_W-1:0] rd_cnt;

  vdp_reg_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_host_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (host_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Accept decisions and arbitration; an empty FIFO lets an accepted host
  // write go straight to the output so it can issue the cycle after accept.
  always_comb begin
    host_entry.addr = host_address;
    host_entry.data = host_write_data;
    win_idx         = lowest_set(32'(ch_write_en));
    ch_entry.addr   = ch_write_address[win_idx*ADDR_W +: ADDR_W];
    ch_entry.data   = ch_write_data[win_idx*DATA_W +: DATA_W];
    any_ch          = |ch_write_en;
    wr_acc          = host_write_en && !fifo_full && !ack_pending && !host_read_en;
    drain           = !any_ch && (!fifo_empty || wr_acc) && !vram_write_pending;
    fifo_push       = wr_acc && !(fifo_empty && drain);
    fifo_pop        = drain && !fifo_empty;
    // Reads wait for every queued write, including one issuing right now.
    rd_acc          = host_read_en && fifo_empty && !fifo_issue && !ack_pending;
  end

  // Host handshake: one ready pulse per request, read address and latency countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_pending  <= 1'b0;
      ready        <= 1'b0;
      rd_cnt       <= '0;
      read_address <= '0;
    end else begin
      ready <= wr_acc || (rd_acc && (READ_LATENCY == 1)) || (rd_cnt == RC_W'(1));
      if (rd_acc) begin
        read_address <= host_address;
        rd_cnt       <= RC_W'(READ_LATENCY - 1);
      end else if (rd_cnt != '0) begin
        rd_cnt <= rd_cnt - 1'b1;
      end
      if (wr_acc || rd_acc) begin
        ack_pending <= 1'b1;
      end else if (!host_write_en && !host_read_en && (rd_cnt == '0)) begin
        ack_pending <= 1'b0;
      end
    end
  end

  // Registered write port: winning channel first, otherwise the host head.
  always_ff @(posedge clk) begin
    if (reset) begin
      register_write_en      <= 1'b0;
      register_write_address <= '0;
      register_write_data    <= '0;
      fifo_issue             <= 1'b0;
    end else begin
      register_write_en <= any_ch || drain;
      fifo_issue        <= drain;
      if (any_ch) begin
        register_write_address <= ch_entry.addr;
        register_write_data    <= ch_entry.data;
      end else if (drain) begin
        register_write_address <= fifo_empty ? host_entry.addr : head_entry.addr;
        register_write_data    <= fifo_empty ? host_entry.data : head_entry.data;
      end
    end
  end

`ifdef VDP_REG_ARB_CONFLICT_COUNT_EN
  logic [7:0] conflict_q;
  int         drops;
  int         sum;

  // Every asserted strobe except the winner is a dropped write.
  always_comb begin
    drops = $countones(ch_write_en) - (any_ch ? 1 : 0);
    sum   = int'(conflict_q) + drops;
  end

  // Saturating count of dropped channel writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (drops != 0) begin
      conflict_q <= (sum > 255) ? 8'd255 : sum[7:0];
    end
  end

`ifndef SYNTHESIS
  // Report which channels collided and which one won.
  always_ff @(posedge clk) begin
    if (!reset && (drops != 0)) begin
      $display("vdp_reg_arbiter: channel conflict strobes=%b winner=%0d", ch_write_en, win_idx);
    end
  end
`endif

  assign conflict_count = conflict_q;
`else
  assign conflict_count = 8'd0;
`endif

endmodule

// File: tb/tb_vdp_reg_arbiter.sv
// Bench for vdp_reg_arbiter: directed scenarios plus a randomized phase.
// Channel writes are expected exactly one cycle after their strobe; host
// writes are expected in request order in whatever cycles channels leave free.
module tb_vdp_reg_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  host_address;
  logic        host_write_en;
  logic [15:0] host_write_data;
  logic        host_read_en;
  logic        ready;
  logic [4:0]  read_address;
  logic [1:0]  ch_write_en;
  logic [9:0]  ch_write_address;
  logic [31:0] ch_write_data;
  logic        vram_write_pending;
  logic        register_write_en;
  logic [4:0]  register_write_address;
  logic [15:0] register_write_data;
  logic [2:0]  fifo_level;
  logic [7:0]  conflict_count;

  vdp_reg_arbiter #(
    .ADDR_W(5), .DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(4), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .host_address(host_address), .host_write_en(host_write_en),
    .host_write_data(host_write_data), .host_read_en(host_read_en),
    .ready(ready), .read_address(read_address),
    .ch_write_en(ch_write_en), .ch_write_address(ch_write_address),
    .ch_write_data(ch_write_data), .vram_write_pending(vram_write_pending),
    .register_write_en(register_write_en),
    .register_write_address(register_write_address),
    .register_write_data(register_write_data),
    .fifo_level(fifo_level), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t       ch_q[$];
  exp_t       host_q[$];
  int         host_log[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         exp_conf = 0;
  int         last_host_issue = -1;
  logic       vram_prev = 1'b0;
  logic [4:0] last_rd = 5'd0;
  bit         host_done = 1'b0;
  logic [4:0] rnd_a;
  bit         ok;
  int         rc;
  int         req;
  int         k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int exp_cc();
`ifdef VDP_REG_ARB_CONFLICT_COUNT_EN
    return (exp_conf > 255) ? 255 : exp_conf;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor: every register write must match a channel write due
  // this cycle or else the oldest outstanding host write.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      while (ch_q.size() > 0 && ch_q[0].cyc < cyc) begin
        e = ch_q.pop_front();
        checks++;
        errors++;
        $display("FAIL ch_write_missing: addr 0x%0h due cycle %0d not seen", e.a, e.cyc);
      end
      if (register_write_en) begin
        if (ch_q.size() > 0 && ch_q[0].cyc == cyc) begin
          e = ch_q.pop_front();
          chk("ch_wr_addr", 32'(register_write_address), 32'(e.a));
          chk("ch_wr_data", 32'(register_write_data), 32'(e.d));
        end else if (host_q.size() > 0) begin
          e = host_q.pop_front();
          chk("host_wr_addr", 32'(register_write_address), 32'(e.a));
          chk("host_wr_data", 32'(register_write_data), 32'(e.d));
          chk("host_wr_vram_idle", 32'(vram_prev), 32'd0);
          last_host_issue = cyc;
          host_log.push_back(cyc);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", register_write_address, register_write_data);
        end
      end
    end
    vram_prev = vram_write_pending;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ch_drive(input logic [1:0] en, input logic [4:0] a0, input logic [15:0] d0,
                          input logic [4:0] a1, input logic [15:0] d1);
    ch_write_en      = en;
    ch_write_address = {a1, a0};
    ch_write_data    = {d1, d0};
    if (en[0])      ch_q.push_back('{cyc + 1, a0, d0});
    else if (en[1]) ch_q.push_back('{cyc + 1, a1, d1});
    if (en == 2'b11) exp_conf++;
  endtask

  task automatic wr_begin(input logic [4:0] a, input logic [15:0] d, output int rq);
    step();
    host_address    = a;
    host_write_data = d;
    host_write_en   = 1'b1;
    rq = cyc;
    host_q.push_back('{0, a, d});
  endtask

  task automatic wait_ready(input int maxw, output bit got, output int rcyc);
    got  = 1'b0;
    rcyc = -1;
    for (int i = 0; i < maxw; i++) begin
      @(negedge clk);
      #1;
      if (ready) begin
        got  = 1'b1;
        rcyc = cyc;
        break;
      end
    end
  endtask

  task automatic host_end();
    step();
    host_write_en = 1'b0;
    host_read_en  = 1'b0;
    @(negedge clk);
    chk("ready_single_pulse", 32'(ready), 32'd0);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [15:0] d, input int maxw);
    bit g;
    int r;
    int q;
    wr_begin(a, d, q);
    wait_ready(maxw, g, r);
    chk("wr_ready_seen", 32'(g), 32'd1);
    host_end();
  endtask

  task automatic rd_begin(input logic [4:0] a);
    step();
    host_address = a;
    host_read_en = 1'b1;
  endtask

  task automatic rd_wait(input logic [4:0] a, input int maxw);
    int  seen;
    int  r;
    bit  g;
    seen = -1;
    r    = -1;
    g    = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      @(negedge clk);
      #1;
      if (seen < 0 && read_address === a) begin
        seen = cyc;
        chk("rd_after_writes", 32'(host_q.size()), 32'd0);
      end
      if (ready) begin
        g = 1'b1;
        r = cyc;
        break;
      end
    end
    chk("rd_ready_seen", 32'(g), 32'd1);
    if (g) begin
      chk("rd_addr", 32'(read_address), 32'(a));
      chk("rd_latency", 32'(r - seen), 32'(RL - 1));
    end
    last_rd = a;
    host_end();
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1;
    host_q.delete();
    ch_q.delete();
    exp_conf = 0;
    last_rd  = 5'd0;
    step();
    step();
    @(negedge clk);
    chk("reset_midop_level", 32'(fifo_level), 32'd0);
    chk("reset_midop_wr_en", 32'(register_write_en), 32'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    host_address       = 5'd9;
    host_write_data    = 16'h1234;
    host_write_en      = 1'b1;
    host_read_en       = 1'b0;
    ch_write_en        = 2'b00;
    ch_write_address   = '0;
    ch_write_data      = '0;
    vram_write_pending = 1'b0;

    // Reset with a host write held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_wr_en", 32'(register_write_en), 32'd0);
    chk("reset_wr_addr", 32'(register_write_address), 32'd0);
    chk("reset_wr_data", 32'(register_write_data), 32'd0);
    chk("reset_rd_addr", 32'(read_address), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_conflicts", 32'(conflict_count), 32'd0);
    host_q.push_back('{0, 5'd9, 16'h1234});
    step();
    reset = 1'b0;
    wait_ready(5, ok, rc);
    chk("reset_held_write_ready", 32'(ok), 32'd1);
    host_end();

    // Basic host write, VRAM idle
    wr_begin(5'd3, 16'hBEEF, req);
    wait_ready(10, ok, rc);
    chk("basic_ready_latency", 32'(rc - req), 32'd1);
    host_end();
    repeat (2) step();
    chk("basic_issue_cycle", 32'(last_host_issue), 32'(req + 1));

    // VRAM stall fills the FIFO; fifth write stalls until a pop frees space
    step();
    vram_write_pending = 1'b1;
    for (int i = 0; i < 4; i++) host_write(5'(i + 10), 16'($urandom), 10);
    wr_begin(5'd20, 16'($urandom), req);
    wait_ready(6, ok, rc);
    chk("full_stall_no_ready", 32'(ok), 32'd0);
    chk("full_level", 32'(fifo_level), 32'd4);
    host_log.delete();
    step();
    vram_write_pending = 1'b0;
    wait_ready(20, ok, rc);
    chk("full_fifth_accepted", 32'(ok), 32'd1);
    host_end();
    repeat (4) step();
    chk("full_issue_count", 32'(host_log.size()), 32'd5);
    if (host_log.size() >= 5) chk("full_back_to_back", 32'(host_log[4] - host_log[0]), 32'd4);

    // Two channels collide while the FIFO holds a host write
    step();
    vram_write_pending = 1'b1;
    host_write(5'd30, 16'hA5A5, 10);
    step();
    vram_write_pending = 1'b0;
    k = cyc;
    ch_drive(2'b11, 5'd1, 16'($urandom), 5'd2, 16'($urandom));
    step();
    ch_write_en = 2'b00;
    repeat (3) step();
    chk("prio_fifo_next_cycle", 32'(last_host_issue), 32'(k + 2));
    chk("prio_conflict_count", 32'(conflict_count), 32'(exp_cc()));

    // Read must wait behind queued writes
    step();
    vram_write_pending = 1'b1;
    host_write(5'd4, 16'h1111, 10);
    host_write(5'd5, 16'h2222, 10);
    rd_begin(5'd7);
    repeat (4) step();
    vram_write_pending = 1'b0;
    rd_wait(5'd7, 50);

    // Reset mid-operation discards queued writes; a held read is served afresh
    step();
    vram_write_pending = 1'b1;
    host_write(5'd8, 16'h3333, 10);
    host_write(5'd9, 16'h4444, 10);
    chk("midop_level", 32'(fifo_level), 32'd2);
    rd_begin(5'd5);
    repeat (2) step();
    apply_reset();
    vram_write_pending = 1'b0;
    rd_wait(5'd5, 20);

    // Randomized traffic: host writes/reads against channel strobes and VRAM stalls
    fork
      begin
        repeat (40) begin
          if ($urandom % 4 == 0) begin
            rnd_a = 5'($urandom);
            while (rnd_a == last_rd) rnd_a = 5'($urandom);
            rd_begin(rnd_a);
            rd_wait(rnd_a, 300);
          end else begin
            host_write(5'($urandom), 16'($urandom), 300);
          end
          repeat ($urandom % 3) step();
        end
        host_done = 1'b1;
      end
      begin
        while (!host_done) begin
          step();
          vram_write_pending = ($urandom % 4 == 0);
          ch_drive({($urandom % 5 == 0), ($urandom % 5 == 0)}, 5'($urandom), 16'($urandom),
                   5'($urandom), 16'($urandom));
        end
        ch_write_en        = 2'b00;
        vram_write_pending = 1'b0;
      end
    join
    repeat (5) step();
    chk("random_conflict_count", 32'(conflict_count), 32'(exp_cc()));

    // Saturation of the conflict counter
    repeat (300) begin
      step();
      ch_drive(2'b11, 5'($urandom), 16'($urandom), 5'($urandom), 16'($urandom));
    end
    step();
    ch_write_en = 2'b00;
    repeat (2) step();
    chk("sat_conflict_count", 32'(conflict_count), 32'(exp_cc()));

    // Everything expected must have issued
    for (int i = 0; i < 100 && (host_q.size() > 0 || ch_q.size() > 0); i++) step();
    chk("drain_host_q", 32'(host_q.size()), 32'd0);
    chk("drain_ch_q", 32'(ch_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
